// File: rtl/ahb_gpio_sequencer.sv
// rtl/ahb_gpio_sequencer.sv - round-robin sharing of one AHB GPIO slave between NUM_REQ command requesters
// Optional data-phase timeout is compiled in with GPIO_SEQ_TIMEOUT_EN.
module ahb_gpio_sequencer #(
    parameter int          NUM_REQ     = 2,
    parameter int          DATA_W      = 16,
    parameter logic [31:0] DATA_ADDR   = 32'h0,
    parameter logic [31:0] DIR_ADDR    = 32'h4,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ-1:0]         req_dir,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       par_err_sticky,
    input  logic                       err_clr,
    output logic                       busy,
    output logic                       HSEL,
    output logic [1:0]                 HTRANS,
    output logic                       HWRITE,
    output logic [31:0]                HADDR,
    output logic                       HREADY,
    output logic [31:0]                HWDATA,
    input  logic [31:0]                HRDATA,
    input  logic                       HREADYOUT,
    input  logic                       PARITYERR
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

`ifdef GPIO_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  cur_idx;
    logic              cur_write;
    logic              cur_dir;
    logic [DATA_W-1:0] cur_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic [PTR_W-1:0]   grant_idx;
    logic               grant_found;
    logic [PTR_W:0]     cand;
    logic [DATA_W-1:0]  sel_wdata;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [NUM_REQ-1:0] cur_onehot;
    logic               timeout_hit;

    // Search starts one past the last winner so every valid requester gets a turn.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_idx   = cand[PTR_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    assign cur_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_idx;

    assign timeout_hit = TIMEOUT_EN && !HREADYOUT && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            cur_idx   <= '0;
            cur_write <= 1'b0;
            cur_dir   <= 1'b0;
            cur_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        cur_idx   <= grant_idx;
                        cur_write <= req_write[grant_idx];
                        cur_dir   <= req_dir[grant_idx];
                        cur_wdata <= sel_wdata;
                        ptr       <= grant_idx;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    wait_cnt <= '0;
                    state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (HREADYOUT) begin
                        rdata_q <= cur_write ? '0 : HRDATA[DATA_W-1:0];
                        err_q   <= PARITYERR;
                        state   <= ST_RESP;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A set in the same cycle as err_clr must not be lost.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            par_err_sticky <= 1'b0;
        end else if (state == ST_DATA && HREADYOUT && PARITYERR) begin
            par_err_sticky <= 1'b1;
        end else if (err_clr) begin
            par_err_sticky <= 1'b0;
        end
    end

    assign req_ready = (state == ST_IDLE && grant_found) ? grant_onehot : '0;
    assign busy      = (state != ST_IDLE);

    assign HSEL   = (state == ST_ADDR);
    assign HTRANS = (state == ST_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE = (state == ST_ADDR) && cur_write;
    assign HADDR  = (state == ST_ADDR) ? (cur_dir ? DIR_ADDR : DATA_ADDR) : 32'h0;
    assign HREADY = (state == ST_DATA) ? HREADYOUT : 1'b1;
    assign HWDATA = (state == ST_DATA && cur_write) ? 32'(cur_wdata) : 32'h0;

    assign rsp_valid = (state == ST_RESP) ? cur_onehot : '0;
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : '0;
    assign rsp_err   = (state == ST_RESP) && err_q;

    generate
        if (DATA_W < 32) begin : g_hrdata_upper
            logic unused_hrdata;
            assign unused_hrdata = ^HRDATA[31:DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_ahb_gpio_sequencer.sv
// tb/tb_ahb_gpio_sequencer.sv - directed self-checking bench for ahb_gpio_sequencer
module tb_ahb_gpio_sequencer;

    logic        HCLK;
    logic        HRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [1:0]  req_dir;
    logic [31:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        par_err_sticky;
    logic        err_clr;
    logic        busy;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        PARITYERR;

    int checks = 0;
    int errors = 0;

    ahb_gpio_sequencer dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_dir        (req_dir),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .par_err_sticky (par_err_sticky),
        .err_clr        (err_clr),
        .busy           (busy),
        .HSEL           (HSEL),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HADDR          (HADDR),
        .HREADY         (HREADY),
        .HWDATA         (HWDATA),
        .HRDATA         (HRDATA),
        .HREADYOUT      (HREADYOUT),
        .PARITYERR      (PARITYERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;

        HRESET    = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_dir   = 2'b00;
        req_wdata = 32'h0;
        err_clr   = 1'b0;
        HRDATA    = 32'h0;
        HREADYOUT = 1'b1;
        PARITYERR = 1'b0;

        // Reset state
        tick();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_hsel",   32'(HSEL), 0);
        chk("rst_htrans", 32'(HTRANS), 0);
        chk("rst_hready", 32'(HREADY), 1);
        chk("rst_sticky", 32'(par_err_sticky), 0);
        chk("rst_rspv",   32'(rsp_valid), 0);
        HRESET = 1'b0;

        // 1: req0 write DATA 16'hA5A5
        req_valid = 2'b01;
        req_write = 2'b01;
        req_wdata = 32'h0000_A5A5;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_hsel",   32'(HSEL), 1);
        chk("t1_haddr",  HADDR, 32'h0);
        chk("t1_htrans", 32'(HTRANS), 2);
        chk("t1_hwrite", 32'(HWRITE), 1);
        chk("t1_ready_addr", 32'(req_ready), 0);
        tick();
        chk("t1_hwdata", HWDATA, 32'h0000_A5A5);
        chk("t1_hsel_data", 32'(HSEL), 0);
        chk("t1_hready", 32'(HREADY), 1);
        tick();
        chk("t1_rspv", 32'(rsp_valid), 32'h1);
        chk("t1_rsperr", 32'(rsp_err), 0);
        chk("t1_rdata", 32'(rsp_rdata), 0);
        tick();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_rspv", 32'(rsp_valid), 0);

        // 2: both requesters read continuously; grants alternate 0,1,0,1
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        req_write = 2'b00;
        req_dir   = 2'b00;
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("t2_ready", 32'(req_ready), 32'(exp_g));
            tick();
            chk("t2_hwrite", 32'(HWRITE), 0);
            chk("t2_ready_busy", 32'(req_ready), 0);
            tick();
            HRDATA = 32'hFFFF_1230 + 32'(t);
            #1;
            chk("t2_hwdata", HWDATA, 32'h0);
            tick();
            chk("t2_rspv", 32'(rsp_valid), 32'(exp_g));
            chk("t2_rdata", 32'(rsp_rdata), 32'h1230 + 32'(t));
            tick();
        end
        req_valid = 2'b00;

        // 3: req1 read DIR with three wait states
        req_valid = 2'b10;
        req_dir   = 2'b10;
        #1;
        chk("t3_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        req_dir   = 2'b00;
        #1;
        chk("t3_haddr", HADDR, 32'h4);
        for (int w = 0; w < 3; w++) begin
            tick();
            HREADYOUT = 1'b0;
            HRDATA    = 32'h0000_DEAD;
            #1;
            chk("t3_hready_wait", 32'(HREADY), 0);
            chk("t3_rspv_wait", 32'(rsp_valid), 0);
        end
        tick();
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0000_00FF;
        #1;
        chk("t3_hready_done", 32'(HREADY), 1);
        tick();
        chk("t3_rspv", 32'(rsp_valid), 32'h2);
        chk("t3_rdata", 32'(rsp_rdata), 32'h00FF);
        tick();

        // 4: parity error with simultaneous err_clr; set wins
        req_valid = 2'b01;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        HRDATA    = 32'h0000_1234;
        PARITYERR = 1'b1;
        err_clr   = 1'b1;
        tick();
        PARITYERR = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk("t4_rspv", 32'(rsp_valid), 32'h1);
        chk("t4_rsperr", 32'(rsp_err), 1);
        chk("t4_rdata", 32'(rsp_rdata), 32'h1234);
        chk("t4_sticky_set", 32'(par_err_sticky), 1);
        tick();
        chk("t4_sticky_hold", 32'(par_err_sticky), 1);
        chk("t4_rsperr_idle", 32'(rsp_err), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("t4_sticky_clr", 32'(par_err_sticky), 0);

        // 5: reset during the data phase aborts the transfer
        req_valid = 2'b01;
        req_write = 2'b01;
        req_wdata = 32'h0000_5A5A;
        tick();
        req_valid = 2'b00;
        tick();
        HREADYOUT = 1'b0;
        #1;
        chk("t5_busy_data", 32'(busy), 1);
        HRESET = 1'b1;
        tick();
        HRESET    = 1'b0;
        HREADYOUT = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_hsel", 32'(HSEL), 0);
        chk("t5_rspv", 32'(rsp_valid), 0);
        chk("t5_hready", 32'(HREADY), 1);
        req_valid = 2'b01;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("t5_hwdata", HWDATA, 32'h0000_5A5A);
        tick();
        chk("t5_rspv_new", 32'(rsp_valid), 32'h1);
        tick();
        req_write = 2'b00;

`ifdef GPIO_SEQ_TIMEOUT_EN
        // 6: slave never ready; response forced after 16 waiting cycles
        req_valid = 2'b10;
        #1;
        chk("t6_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        HREADYOUT = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t6_rspv_wait", 32'(rsp_valid), 0);
            tick();
        end
        chk("t6_rspv", 32'(rsp_valid), 32'h2);
        chk("t6_rsperr", 32'(rsp_err), 1);
        chk("t6_rdata", 32'(rsp_rdata), 0);
        chk("t6_sticky", 32'(par_err_sticky), 0);
        HREADYOUT = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
